// File: rtl/der_pipe_pkg.sv
// Shared types and helpers for the derivative pipeline sequencing controller.
package der_pipe_pkg;

    typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} ctrl_state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eol;
        logic border;
    } tok_side_t;

    // True when the pixel lies within the kernel half-width of any frame edge.
    function automatic logic is_border(input int unsigned col, input int unsigned row,
                                       input int unsigned fw, input int unsigned fh,
                                       input int unsigned kw);
        int unsigned half;
        half = kw / 2;
        return (col < half) || (col >= fw - half) || (row < half) || (row >= fh - half);
    endfunction

endpackage

// File: rtl/der_pipe_ctrl_en_delay_line.sv
// Enable-gated shift register with synchronous clear; tracks tokens through the datapath.
module en_delay_line #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;

    always_comb begin
        stage_d = stage_q;
        if (clr) begin
            stage_d = '0;
        end else if (en) begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/der_pipe_ctrl.sv
// Sequencing controller for the derivative datapath: priming, run, drain and done.
// Optional stall/starve statistics outputs are enabled with DER_PIPE_CTRL_STATS_EN.
module der_pipe_ctrl
    import der_pipe_pkg::*;
#(
    parameter int FRAME_WIDTH    = 1024,
    parameter int FRAME_HEIGHT   = 768,
    parameter int KERNEL_WIDTH   = 5,
    parameter int PIPE_LATENCY   = 3,
    parameter int PRIME_FRAMES   = 6,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [FRAME_CNT_BITS-1:0] num_frames,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      der_en,
    output logic                      out_valid,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      out_border,
    output logic [FRAME_CNT_BITS-1:0] frame_idx,
    output logic                      busy,
    output logic                      done
`ifdef DER_PIPE_CTRL_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               starve_cycles
`endif
);

    localparam int COL_W = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
    localparam int ROW_W = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int DRN_W = $clog2(PIPE_LATENCY + 1);

    ctrl_state_t               state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [FRAME_CNT_BITS-1:0] frame_q, frame_d;
    logic [FRAME_CNT_BITS-1:0] nframes_q, nframes_d;
    logic [DRN_W-1:0]          drain_q, drain_d;

    logic      start_acc, accept, last_col, last_pix, seq_end, prime_end;
    tok_side_t tok_in, tok_out;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        frame_d   = frame_q;
        nframes_d = nframes_q;
        drain_d   = drain_q;
        in_ready  = 1'b0;
        der_en    = 1'b0;
        start_acc = 1'b0;
        tok_in    = '0;

        last_col  = (col_q == COL_W'(FRAME_WIDTH - 1));
        last_pix  = last_col && (row_q == ROW_W'(FRAME_HEIGHT - 1));
        seq_end   = last_pix && (frame_q == nframes_q - FRAME_CNT_BITS'(1));
        prime_end = last_pix && (frame_q == FRAME_CNT_BITS'(PRIME_FRAMES - 1));

        tok_in.sof    = (col_q == '0) && (row_q == '0);
        tok_in.eol    = last_col;
        tok_in.border = is_border(32'(col_q), 32'(row_q), FRAME_WIDTH, FRAME_HEIGHT, KERNEL_WIDTH);

        case (state_q)
            IDLE: begin
                tok_in = '0;
                if (start) begin
                    start_acc = 1'b1;
                    nframes_d = num_frames;
                    col_d     = '0;
                    row_d     = '0;
                    frame_d   = '0;
                    drain_d   = '0;
                    state_d   = (num_frames == '0) ? DONE : PRIME;
                end
            end
            PRIME: begin
                in_ready = 1'b1;
                der_en   = in_valid;
                // Short sequences end inside priming and skip RUN entirely.
                if (in_valid && seq_end)        state_d = DRAIN;
                else if (in_valid && prime_end) state_d = RUN;
            end
            RUN: begin
                in_ready     = out_ready;
                der_en       = in_valid && out_ready;
                tok_in.valid = 1'b1;
                if (der_en && seq_end) state_d = DRAIN;
            end
            DRAIN: begin
                tok_in = '0;
                der_en = out_ready;
                if (out_ready) begin
                    drain_d = drain_q + DRN_W'(1);
                    if (drain_q == DRN_W'(PIPE_LATENCY - 1)) state_d = DONE;
                end
            end
            DONE: begin
                tok_in  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        accept = in_valid && in_ready;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                if (row_q == ROW_W'(FRAME_HEIGHT - 1)) begin
                    row_d   = '0;
                    frame_d = frame_q + FRAME_CNT_BITS'(1);
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            frame_q   <= '0;
            nframes_q <= '0;
            drain_q   <= '0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            nframes_q <= nframes_d;
            drain_q   <= drain_d;
        end
    end

    en_delay_line #(
        .DEPTH(PIPE_LATENCY),
        .WIDTH($bits(tok_side_t))
    ) u_side_dly (
        .clk (clk),
        .rst (rst),
        .clr (start_acc),
        .en  (der_en),
        .din (tok_in),
        .dout(tok_out)
    );

    assign out_valid  = tok_out.valid;
    assign out_sof    = tok_out.valid && tok_out.sof;
    assign out_eol    = tok_out.valid && tok_out.eol;
    assign out_border = tok_out.valid && tok_out.border;
    assign frame_idx  = frame_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);

`ifdef DER_PIPE_CTRL_STATS_EN
    logic [31:0] stall_q, stall_d, starve_q, starve_d;

    always_comb begin
        stall_d  = stall_q;
        starve_d = starve_q;
        if (start_acc) begin
            stall_d  = '0;
            starve_d = '0;
        end else if (state_q == RUN) begin
            if (in_valid && !out_ready && (stall_q != '1)) stall_d  = stall_q + 32'd1;
            if (!in_valid && (starve_q != '1))             starve_d = starve_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            starve_q <= '0;
        end else begin
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign stall_cycles  = stall_q;
    assign starve_cycles = starve_q;
`endif

endmodule

// File: tb/tb_der_pipe_ctrl.sv
// Randomized scoreboard bench for der_pipe_ctrl with a token-index reference model.
module tb_der_pipe_ctrl;

    localparam int FW = 8, FH = 4, KW = 5, PL = 3, PF = 2, CB = 16;
    localparam int TOK = FW * FH, HALF = KW / 2;

    logic          clk = 1'b0;
    logic          rst, start, in_valid, out_ready;
    logic [CB-1:0] num_frames;
    logic          in_ready, der_en, out_valid, out_sof, out_eol, out_border, busy, done;
    logic [CB-1:0] frame_idx;
`ifdef DER_PIPE_CTRL_STATS_EN
    logic [31:0]   stall_cycles, starve_cycles;
`endif

    der_pipe_ctrl #(
        .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .KERNEL_WIDTH(KW),
        .PIPE_LATENCY(PL), .PRIME_FRAMES(PF), .FRAME_CNT_BITS(CB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_frames(num_frames),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .der_en(der_en), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
        .out_border(out_border), .frame_idx(frame_idx), .busy(busy), .done(done)
`ifdef DER_PIPE_CTRL_STATS_EN
        , .stall_cycles(stall_cycles), .starve_cycles(starve_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed { logic sof; logic eol; logic bord; } exp_t;
    exp_t q[$];

    int n_acc, n_out, n_sof, n_eol, n_bord, exp_bord, n_den, n_done, n_irdy;
    int first_run_acc, first_out, last_den, done_cyc, start_cyc;
    logic       stalled_prev = 1'b0, rst_prev = 1'b1;
    logic [3:0] prev_out = '0;

    // Monitor first, then model update, so a reset in the same cycle discards everything.
    always @(negedge clk) begin
        exp_t e;
        int   k, f, p, c, r;
        if (stalled_prev && !rst_prev)
            chk("stall_hold", {out_valid, out_sof, out_eol, out_border}, prev_out);
        if (out_valid && der_en) begin
            n_out++;
            if (out_sof)    n_sof++;
            if (out_eol)    n_eol++;
            if (out_border) n_bord++;
            if (first_out < 0) first_out = cyc;
            if (q.size() == 0) chk("unexpected_token", 1, 0);
            else begin
                e = q.pop_front();
                chk("token_sideband", {out_sof, out_eol, out_border}, e);
            end
        end
        if (der_en)   begin n_den++; last_den = cyc; end
        if (in_ready) n_irdy++;
        if (done)     begin n_done++; done_cyc = cyc; end
        stalled_prev = out_valid && !der_en;
        prev_out     = {out_valid, out_sof, out_eol, out_border};
        rst_prev     = rst;
        if (rst) q.delete();
        else begin
            if (start && !busy) begin
                n_acc = 0; n_out = 0; n_sof = 0; n_eol = 0; n_bord = 0; exp_bord = 0;
                n_den = 0; n_done = 0; n_irdy = 0; first_run_acc = -1; first_out = -1;
                start_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                k = n_acc; f = k / TOK; p = k % TOK; c = p % FW; r = p / FW;
                if (f >= PF) begin
                    e.sof  = (p == 0);
                    e.eol  = (c == FW - 1);
                    e.bord = (c < HALF) || (c >= FW - HALF) || (r < HALF) || (r >= FH - HALF);
                    if (e.bord) exp_bord++;
                    if (first_run_acc < 0) first_run_acc = cyc;
                    q.push_back(e);
                end
                n_acc++;
            end
        end
    end

    // mode 0: full rate; 1: random in_valid, out_ready toggling every 3 cycles; 2: stats pattern
    task automatic run_seq(input int nf, input int mode, input int rst_at);
        int t, sc;
        t = 0; sc = 0;
        @(posedge clk); #1;
        start = 1'b1; num_frames = CB'(nf); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (n_done == 0 && t < 3000) begin
            if (rst_at > 0 && n_acc >= rst_at) begin
                rst = 1'b1;
                return;
            end
            case (mode)
                1: begin
                    in_valid  = ($urandom_range(0, 4) != 0);
                    out_ready = ((t / 3) % 2) == 0;
                end
                2: begin
                    in_valid = 1'b1; out_ready = 1'b1;
                    if (n_acc >= PF * TOK && sc < 15) begin
                        if (sc < 10) out_ready = 1'b0;
                        else         in_valid  = 1'b0;
                        sc++;
                    end
                end
                default: begin in_valid = 1'b1; out_ready = 1'b1; end
            endcase
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", n_done, 1);
        chk("queue_empty", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; num_frames = CB'(4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_der_en", der_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_frame_idx", frame_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;

        run_seq(4, 0, 0);
        chk("A_out", n_out, 64);
        chk("A_sof", n_sof, 2);
        chk("A_eol", n_eol, 8);
        chk("A_border", n_bord, exp_bord);
        chk("A_der_en", n_den, 131);
        chk("A_latency", first_out - first_run_acc, 3);
        chk("A_done_after_drain", done_cyc - last_den, 1);

        run_seq(4, 1, 0);
        chk("B_out", n_out, 64);
        chk("B_acc", n_acc, 128);

        run_seq(2, 0, 0);
        chk("C_acc", n_acc, 64);
        chk("C_out", n_out, 0);

        run_seq(0, 0, 0);
        chk("D_done_latency", done_cyc - start_cyc, 1);
        chk("D_in_ready", n_irdy, 0);

        run_seq(4, 0, 3 * TOK + 5);
        @(posedge clk);
        @(negedge clk);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_out_valid", out_valid, 0);
        chk("E_rst_in_ready", in_ready, 0);
        chk("E_rst_der_en", der_en, 0);
        chk("E_rst_frame_idx", frame_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_seq(3, 0, 0);
        chk("E_out", n_out, 32);

`ifdef DER_PIPE_CTRL_STATS_EN
        run_seq(4, 2, 0);
        chk("S_stall", stall_cycles, 10);
        chk("S_starve", starve_cycles, 5);
        chk("S_out", n_out, 64);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
